decode_stage_pipe: RTL and testbench

- Parametrised, pipelined RV32I decode stage that sits between fetch and execute.
- Decodes all base formats (R/I/S/B/U/J) and reads the register file.
- Takes write-back from a separate port.
- Registers its results into an ID/EX register with valid/ready handshake, flush and a load-use bubble.

---
 rtl/decode_pkg.sv | 79 +++++++
 rtl/decode_stage_pipe_ctrl.sv | 109 ++++++++++
 rtl/decode_stage_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32I decode stage.
//   - RV32I opcode constants (OP_*)
//   - alu_op_e   : ALU operation encoding driven to execute
//   - imm_sel_e  : immediate format selector
//   - opa_sel_e  : operand A source selector
//   - id_ex_t    : control half of the ID/EX pipeline register
//   - arith_alu(): funct3/bit30 to ALU operation for OP and OP-IMM
package decode_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_sel_e;

    typedef enum logic [1:0] {
        OPA_RS1,
        OPA_PC,
        OPA_ZERO
    } opa_sel_e;

    typedef struct packed {
        logic    valid;
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
    } id_ex_t;

    // bit30 selects SUB only for register-register ops; SRA/SRAI use it in both.
    function automatic alu_op_e arith_alu(input logic [2:0] funct3,
                                          input logic       bit30,
                                          input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_ctrl.sv
// decode_ctrl: combinational opcode/funct3/bit30 decoder.
// Ports:
//   opcode_i, funct3_i, funct7_5_i : instruction fields (funct7_5_i = instr[30])
//   known_o                        : opcode is one of the supported RV32I formats
//   reg_write_o .. jump_o          : control flags
//   use_rs1_o, use_rs2_o           : source registers actually read (hazard check)
//   imm_sel_o, opa_sel_o, opb_rs2_o: datapath selectors
//   alu_op_o                       : ALU operation
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic       known_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       branch_o,
    output logic       jump_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output imm_sel_e   imm_sel_o,
    output opa_sel_e   opa_sel_o,
    output logic       opb_rs2_o,
    output alu_op_e    alu_op_o
);

    always_comb begin
        known_o     = 1'b0;
        reg_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        branch_o    = 1'b0;
        jump_o      = 1'b0;
        use_rs1_o   = 1'b1;
        use_rs2_o   = 1'b0;
        imm_sel_o   = IMM_NONE;
        opa_sel_o   = OPA_RS1;
        opb_rs2_o   = 1'b0;
        alu_op_o    = ALU_ADD;

        case (opcode_i)
            OP_R: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                use_rs2_o   = 1'b1;
                opb_rs2_o   = 1'b1;
                alu_op_o    = arith_alu(funct3_i, funct7_5_i, 1'b1);
            end
            OP_IMM: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                imm_sel_o   = IMM_I;
                alu_op_o    = arith_alu(funct3_i, funct7_5_i, 1'b0);
            end
            OP_LOAD: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                mem_read_o  = 1'b1;
                imm_sel_o   = IMM_I;
            end
            OP_STORE: begin
                known_o     = 1'b1;
                mem_write_o = 1'b1;
                use_rs2_o   = 1'b1;
                imm_sel_o   = IMM_S;
            end
            OP_BRANCH: begin
                known_o     = 1'b1;
                branch_o    = 1'b1;
                use_rs2_o   = 1'b1;
                opb_rs2_o   = 1'b1;
                imm_sel_o   = IMM_B;
                alu_op_o    = ALU_SUB;
            end
            OP_LUI: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                use_rs1_o   = 1'b0;
                imm_sel_o   = IMM_U;
                opa_sel_o   = OPA_ZERO;
            end
            OP_AUIPC: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                use_rs1_o   = 1'b0;
                imm_sel_o   = IMM_U;
                opa_sel_o   = OPA_PC;
            end
            OP_JAL: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                jump_o      = 1'b1;
                use_rs1_o   = 1'b0;
                imm_sel_o   = IMM_J;
                opa_sel_o   = OPA_PC;
            end
            OP_JALR: begin
                known_o     = 1'b1;
                reg_write_o = 1'b1;
                jump_o      = 1'b1;
                imm_sel_o   = IMM_I;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: pipelined RV32I decode stage with register file and ID/EX register.
// Optional feature macro: WB_BYPASS_EN (write-first forwarding of wb_data_i to reads).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_valid_i / if_ready_o        : fetch handshake; instruction_i, pc_i payload
//   flush_i                        : drop held entry and incoming instruction
//   wb_en_i, wb_rd_i, wb_data_i    : register file write-back
//   ex_ready_i / ex_valid_o        : execute handshake on the ID/EX register
//   alu_control_o, opa_o, opb_o, rs2_data_o, imm_o, pc_o, rd_o : ID/EX payload
//   reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o     : ID/EX control flags
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INSTRUCTION = 32,
    parameter int unsigned ALU_CONTROL = 4,
    parameter int unsigned REG_COUNT   = 32,
    localparam int unsigned RW         = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid_i,
    output logic                   if_ready_o,
    input  logic [INSTRUCTION-1:0] instruction_i,
    input  logic [DATA_WIDTH-1:0]  pc_i,
    input  logic                   flush_i,
    input  logic                   wb_en_i,
    input  logic [RW-1:0]          wb_rd_i,
    input  logic [DATA_WIDTH-1:0]  wb_data_i,
    input  logic                   ex_ready_i,
    output logic                   ex_valid_o,
    output logic [ALU_CONTROL-1:0] alu_control_o,
    output logic [DATA_WIDTH-1:0]  opa_o,
    output logic [DATA_WIDTH-1:0]  opb_o,
    output logic [DATA_WIDTH-1:0]  rs2_data_o,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic [DATA_WIDTH-1:0]  pc_o,
    output logic [RW-1:0]          rd_o,
    output logic                   reg_write_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic                   branch_o,
    output logic                   jump_o
);

    // Instruction fields
    logic [RW-1:0] rs1_addr, rs2_addr, rd_addr;
    assign rs1_addr = RW'(instruction_i[19:15]);
    assign rs2_addr = RW'(instruction_i[24:20]);
    assign rd_addr  = RW'(instruction_i[11:7]);

    // Control decode
    logic     known, reg_write, mem_read, mem_write, branch, jump;
    logic     use_rs1, use_rs2, opb_rs2;
    imm_sel_e imm_sel;
    opa_sel_e opa_sel;
    alu_op_e  alu_op;

    decode_ctrl u_ctrl (
        .opcode_i    (instruction_i[6:0]),
        .funct3_i    (instruction_i[14:12]),
        .funct7_5_i  (instruction_i[30]),
        .known_o     (known),
        .reg_write_o (reg_write),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .branch_o    (branch),
        .jump_o      (jump),
        .use_rs1_o   (use_rs1),
        .use_rs2_o   (use_rs2),
        .imm_sel_o   (imm_sel),
        .opa_sel_o   (opa_sel),
        .opb_rs2_o   (opb_rs2),
        .alu_op_o    (alu_op)
    );

    // Register file
    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_i && (wb_rd_i != '0)) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wb_en_i && (wb_rd_i != '0) && (wb_rd_i == rs1_addr)) rs1_data = wb_data_i;
        if (wb_en_i && (wb_rd_i != '0) && (wb_rd_i == rs2_addr)) rs2_data = wb_data_i;
`endif
    end

    // Immediate generation (32-bit RV32I immediates, then sign-extended to DATA_WIDTH)
    logic signed [31:0]    imm32;
    logic [DATA_WIDTH-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I: imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
            IMM_S: imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            IMM_B: imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                            instruction_i[30:25], instruction_i[11:8], 1'b0};
            IMM_U: imm32 = {instruction_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                            instruction_i[20], instruction_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = DATA_WIDTH'(imm32);
    end

    // ID/EX register state
    id_ex_t                ex_q, ex_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, rs2d_q, rs2d_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d, pc_q, pc_d;
    logic [RW-1:0]         rd_q, rd_d;

    logic hazard, load_en, accept;

    always_comb begin
        hazard = ex_q.valid && ex_q.mem_read && (rd_q != '0) && if_valid_i &&
                 ((use_rs1 && (rs1_addr == rd_q)) || (use_rs2 && (rs2_addr == rd_q)));
        load_en    = !ex_q.valid || ex_ready_i;
        if_ready_o = load_en && !hazard && !flush_i;
        accept     = if_valid_i && if_ready_o;

        // Default: bubble (everything cleared so an invalid entry shows all zeros)
        ex_d   = '0;
        opa_d  = '0;
        opb_d  = '0;
        rs2d_d = '0;
        imm_d  = '0;
        pc_d   = '0;
        rd_d   = '0;

        if (flush_i) begin
            // bubble
        end else if (!load_en) begin
            ex_d   = ex_q;
            opa_d  = opa_q;
            opb_d  = opb_q;
            rs2d_d = rs2d_q;
            imm_d  = imm_q;
            pc_d   = pc_q;
            rd_d   = rd_q;
        end else if (accept && known) begin
            ex_d.valid     = 1'b1;
            ex_d.alu_op    = alu_op;
            ex_d.reg_write = reg_write;
            ex_d.mem_read  = mem_read;
            ex_d.mem_write = mem_write;
            ex_d.branch    = branch;
            ex_d.jump      = jump;
            case (opa_sel)
                OPA_PC:   opa_d = pc_i;
                OPA_ZERO: opa_d = '0;
                default:  opa_d = rs1_data;
            endcase
            opb_d  = opb_rs2 ? rs2_data : imm_ext;
            rs2d_d = rs2_data;
            imm_d  = imm_ext;
            pc_d   = pc_i;
            rd_d   = reg_write ? rd_addr : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            rs2d_q <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            rd_q   <= '0;
        end else begin
            ex_q   <= ex_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            rs2d_q <= rs2d_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            rd_q   <= rd_d;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign alu_control_o = ALU_CONTROL'(ex_q.alu_op);
    assign opa_o         = opa_q;
    assign opb_o         = opb_q;
    assign rs2_data_o    = rs2d_q;
    assign imm_o         = imm_q;
    assign pc_o          = pc_q;
    assign rd_o          = rd_q;
    assign reg_write_o   = ex_q.reg_write;
    assign mem_read_o    = ex_q.mem_read;
    assign mem_write_o   = ex_q.mem_write;
    assign branch_o      = ex_q.branch;
    assign jump_o        = ex_q.jump;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed plus random stimulus for decode_stage_pipe,
// checked against a behavioural model of the stage kept in this file.
// Honors WB_BYPASS_EN for the expected read data.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, wb_en, ex_ready;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_rd;

    logic        if_ready_o, ex_valid_o;
    logic [3:0]  alu_control_o;
    logic [31:0] opa_o, opb_o, rs2_data_o, imm_o, pc_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(
        .DATA_WIDTH  (32),
        .INSTRUCTION (32),
        .ALU_CONTROL (4),
        .REG_COUNT   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid_i    (if_valid),
        .if_ready_o    (if_ready_o),
        .instruction_i (instr),
        .pc_i          (pc),
        .flush_i       (flush),
        .wb_en_i       (wb_en),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .ex_ready_i    (ex_ready),
        .ex_valid_o    (ex_valid_o),
        .alu_control_o (alu_control_o),
        .opa_o         (opa_o),
        .opb_o         (opb_o),
        .rs2_data_o    (rs2_data_o),
        .imm_o         (imm_o),
        .pc_o          (pc_o),
        .rd_o          (rd_o),
        .reg_write_o   (reg_write_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .branch_o      (branch_o),
        .jump_o        (jump_o)
    );

`ifdef WB_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_X2 = 32'h0000_1234;
`else
    localparam logic [31:0] SAME_CYCLE_X2 = 32'h0000_0000;
`endif

    typedef struct packed {
        logic        v;
        logic [3:0]  alu;
        logic [31:0] opa, opb, rs2d, imm, pc;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, jp;
    } ent_t;

    ent_t        m = '0;
    logic [31:0] mreg [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA: what execute should receive.
    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
        ent_t             e;
        logic signed [31:0] t;
        logic [6:0]       op;
        logic [2:0]       f3;
        alu_op_e          tab [8];
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op  = ins[6:0];
        f3  = ins[14:12];
        e   = '0;
        e.v = 1'b1; e.pc = pcv; e.rs2d = r2; e.opa = r1; e.alu = ALU_ADD;
        case (op)
            OP_R: begin
                e.rw = 1'b1; e.alu = tab[f3];
                if (ins[30] && f3 == 3'd0) e.alu = ALU_SUB;
                if (ins[30] && f3 == 3'd5) e.alu = ALU_SRA;
            end
            OP_IMM: begin
                e.rw = 1'b1; e.imm = $signed(ins) >>> 20; e.alu = tab[f3];
                if (ins[30] && f3 == 3'd5) e.alu = ALU_SRA;
            end
            OP_LOAD:  begin e.rw = 1'b1; e.mr = 1'b1; e.imm = $signed(ins) >>> 20; end
            OP_STORE: begin
                e.mw = 1'b1; t = {ins[31:25], ins[11:7], 20'b0}; e.imm = t >>> 20;
            end
            OP_BRANCH: begin
                e.br = 1'b1; e.alu = ALU_SUB;
                t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}; e.imm = t >>> 19;
            end
            OP_LUI:   begin e.rw = 1'b1; e.opa = '0;  e.imm = {ins[31:12], 12'b0}; end
            OP_AUIPC: begin e.rw = 1'b1; e.opa = pcv; e.imm = {ins[31:12], 12'b0}; end
            OP_JAL: begin
                e.rw = 1'b1; e.jp = 1'b1; e.opa = pcv;
                t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}; e.imm = t >>> 11;
            end
            OP_JALR:  begin e.rw = 1'b1; e.jp = 1'b1; e.imm = $signed(ins) >>> 20; end
            default:  e = '0;
        endcase
        if (e.v) e.opb = (op == OP_R || op == OP_BRANCH) ? r2 : e.imm;
        if (e.rw) e.rd = ins[11:7];
        return e;
    endfunction

    // One clock: check if_ready mid-cycle, advance the model, check ID/EX after the edge.
    task automatic step();
        ent_t        nxt;
        logic        hz, rdy, u1, u2;
        logic [4:0]  a1, a2;
        logic [6:0]  op;
        logic [31:0] r1, r2;
        #4;
        op  = instr[6:0];
        a1  = instr[19:15];
        a2  = instr[24:20];
        u1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u2  = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
        hz  = m.v && m.mr && (m.rd != 0) && if_valid &&
              ((u1 && a1 == m.rd) || (u2 && a2 == m.rd));
        rdy = (!m.v || ex_ready) && !hz && !flush;
        if (!rst) chk("if_ready", {31'b0, if_ready_o}, {31'b0, rdy});
        r1 = (a1 == 0) ? 32'h0 : mreg[a1];
        r2 = (a2 == 0) ? 32'h0 : mreg[a2];
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd != 0 && wb_rd == a1) r1 = wb_data;
        if (wb_en && wb_rd != 0 && wb_rd == a2) r2 = wb_data;
`endif
        if (rst || flush)             nxt = '0;
        else if (m.v && !ex_ready)    nxt = m;
        else if (if_valid && rdy)     nxt = ref_decode(instr, pc, r1, r2);
        else                          nxt = '0;
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
        end else if (wb_en && wb_rd != 0) begin
            mreg[wb_rd] = wb_data;
        end
        m = nxt;
        @(posedge clk);
        #1;
        chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, m.v});
        chk("alu", {28'b0, alu_control_o}, {28'b0, m.alu});
        chk("opa", opa_o, m.opa);
        chk("opb", opb_o, m.opb);
        chk("rs2_data", rs2_data_o, m.rs2d);
        chk("imm", imm_o, m.imm);
        chk("pc", pc_o, m.pc);
        chk("rd", {27'b0, rd_o}, {27'b0, m.rd});
        chk("flags", {27'b0, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o},
            {27'b0, m.rw, m.mr, m.mw, m.br, m.jp});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] ins;
        ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                OP_JAL, OP_JALR, 7'b0001111};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
        instr = '0; pc = '0; wb_rd = '0; wb_data = '0;
        step();
        step();
        chk("reset_valid", {31'b0, ex_valid_o}, 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5
        if_valid = 1'b1; instr = 32'h0050_0093; pc = 32'h0000_0010;
        step();
        chk("addi_valid", {31'b0, ex_valid_o}, 32'd1);
        chk("addi_opa", opa_o, 32'd0);
        chk("addi_opb", opb_o, 32'd5);
        chk("addi_rd", {27'b0, rd_o}, 32'd1);
        chk("addi_rw", {31'b0, reg_write_o}, 32'd1);
        chk("addi_alu", {28'b0, alu_control_o}, {28'b0, ALU_ADD});

        // write-back of x2 in the same cycle as ADD x3,x2,x2
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_1234; instr = 32'h0021_01B3;
        step();
        chk("samecyc_opa", opa_o, SAME_CYCLE_X2);
        chk("samecyc_opb", opb_o, SAME_CYCLE_X2);
        wb_en = 1'b0;
        step();
        chk("after_wb_opa", opa_o, 32'h0000_1234);

        // LW x5,0(x1) then ADD x6,x5,x5: one bubble
        instr = 32'h0000_A283;
        step();
        chk("lw_memrd", {31'b0, mem_read_o}, 32'd1);
        instr = 32'h0052_8333;
        step();
        chk("loaduse_bubble", {31'b0, ex_valid_o}, 32'd0);
        step();
        chk("loaduse_issue", {31'b0, ex_valid_o}, 32'd1);
        chk("loaduse_rd", {27'b0, rd_o}, 32'd6);

        // BEQ x1,x1,-4 with x1 written first
        if_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0055;
        step();
        wb_en = 1'b0; if_valid = 1'b1; instr = 32'hFE10_8EE3; pc = 32'h0000_0300;
        step();
        chk("beq_imm", imm_o, 32'hFFFF_FFFC);
        chk("beq_branch", {31'b0, branch_o}, 32'd1);
        chk("beq_opb", opb_o, 32'h0000_0055);

        // JAL x1,+2048
        instr = 32'h0010_00EF; pc = 32'h0000_0100;
        step();
        chk("jal_imm", imm_o, 32'h0000_0800);
        chk("jal_opa", opa_o, 32'h0000_0100);
        chk("jal_jump", {31'b0, jump_o}, 32'd1);

        // Stall for 3 cycles, then flush while stalled
        instr = 32'h0050_0093; pc = 32'h0000_0200;
        step();
        ex_ready = 1'b0; instr = 32'h0052_8333; pc = 32'h0000_0204;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", {31'b0, ex_valid_o}, 32'd1);
            chk("stall_pc", pc_o, 32'h0000_0200);
            chk("stall_opb", opb_o, 32'd5);
            chk("stall_ready", {31'b0, if_ready_o}, 32'd0);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", {31'b0, ex_valid_o}, 32'd0);
        flush = 1'b0; ex_ready = 1'b1;

        // x0 write ignored, ADD x7,x0,x0
        if_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_FFFF;
        step();
        wb_en = 1'b0; if_valid = 1'b1; instr = 32'h0000_03B3;
        step();
        chk("x0_opa", opa_o, 32'd0);
        chk("x0_opb", opb_o, 32'd0);
        chk("x0_valid", {31'b0, ex_valid_o}, 32'd1);

        // Reset while an entry is held
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'b0, ex_valid_o}, 32'd0);
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            instr    = rand_instr();
            pc       = $urandom & 32'hFFFF_FFFC;
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
